io_ctrl: RTL and testbench

IO_CTRL -- requirements
Module: io_ctrl

---
 rtl/io_ctrl.sv | 158 +++++++++++++++
 tb/tb_io_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_ctrl.sv
// Memory-mapped I/O controller: debounced buttons with edge capture and interrupt,
// active-low LEDs and a multiplexed seven-segment hex display.
module io_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int N_BTN     = 4,
    parameter int N_LED     = 4,
    parameter int N_DIG     = 4,
    parameter int DEB_BITS  = 16,
    parameter int SCAN_BITS = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           addr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic                 we,
    output logic [WORD_SIZE-1:0] rdata,
    input  logic [N_BTN-1:0]     btn,
    output logic [N_LED-1:0]     led,
    output logic [7:0]           seg,
    output logic [N_DIG-1:0]     dig,
    output logic                 irq
);

    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIG - 1);

    logic [WORD_SIZE-1:0] disp_reg;
    logic [N_LED-1:0]     led_reg;
    logic [N_BTN-1:0]     level_reg, edge_reg, sample_reg;
    logic [N_BTN-1:0]     sync1_reg, sync2_reg;
    logic [1:0]           ctrl_reg;
    logic [DEB_BITS-1:0]  deb_cnt_reg;
    logic [SCAN_BITS-1:0] scan_cnt_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [7:0]           seg_reg;
    logic [N_DIG-1:0]     dig_reg;
    logic                 irq_reg;
    logic [WORD_SIZE-1:0] rdata_reg;

    logic                 deb_tick, scan_wrap;
    logic                 wr_disp, wr_led, wr_edge, wr_ctrl;
    logic [N_BTN-1:0]     agree, level_next, edge_next, edge_clr;
    logic [IDX_W-1:0]     idx_next;
    logic [3:0]           nibble [N_DIG];
    logic [3:0]           cur_nib;
    logic [7:0]           hex_seg, seg_next;
    logic [N_DIG-1:0]     dig_next;
    logic [WORD_SIZE-1:0] rdata_next;

    assign deb_tick  = &deb_cnt_reg;
    assign scan_wrap = &scan_cnt_reg;
    assign wr_disp   = we && (addr == 3'd0);
    assign wr_led    = we && (addr == 3'd1);
    assign wr_edge   = we && (addr == 3'd3);
    assign wr_ctrl   = we && (addr == 3'd4);

    // A level bit follows the sample only when two consecutive ticks agree.
    assign agree      = ~(sync2_reg ^ sample_reg);
    assign level_next = deb_tick ? ((sync2_reg & agree) | (level_reg & ~agree)) : level_reg;
    assign edge_clr   = wr_edge ? wdata[N_BTN-1:0] : '0;
    // A rising edge landing in the clear cycle wins over the clear.
    assign edge_next  = (edge_reg & ~edge_clr) | (level_next & ~level_reg);

    assign idx_next = scan_wrap ? ((idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1) : idx_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_dig
            assign nibble[gi]   = disp_reg[4*gi +: 4];
            assign dig_next[gi] = !(ctrl_reg[0] && (idx_reg == IDX_W'(gi)));
        end
    endgenerate

    assign cur_nib = nibble[idx_reg];

    always_comb begin
        hex_seg = 8'hFF;
        case (cur_nib)
            4'h0: hex_seg = 8'hC0;
            4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;
            4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;
            4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;
            4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;
            4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;
            4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hC6;
            4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;
            default: hex_seg = 8'h8E;
        endcase
    end

    assign seg_next = ctrl_reg[0] ? hex_seg : 8'hFF;

    always_comb begin
        rdata_next = '0;
        case (addr)
            3'd0: rdata_next = disp_reg;
            3'd1: rdata_next[N_LED-1:0] = led_reg;
            3'd2: rdata_next[N_BTN-1:0] = level_reg;
            3'd3: rdata_next[N_BTN-1:0] = edge_reg;
            3'd4: rdata_next[1:0] = ctrl_reg;
            default: rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_reg     <= '0;
            led_reg      <= '0;
            level_reg    <= '0;
            edge_reg     <= '0;
            sample_reg   <= '0;
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            ctrl_reg     <= 2'b01;
            deb_cnt_reg  <= '0;
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
            seg_reg      <= 8'hFF;
            dig_reg      <= '1;
            irq_reg      <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            sync1_reg    <= btn;
            sync2_reg    <= sync1_reg;
            deb_cnt_reg  <= deb_cnt_reg + DEB_BITS'(1);
            if (deb_tick)
                sample_reg <= sync2_reg;
            level_reg    <= level_next;
            edge_reg     <= edge_next;
            if (wr_disp)
                disp_reg <= wdata;
            if (wr_led)
                led_reg <= wdata[N_LED-1:0];
            if (wr_ctrl)
                ctrl_reg <= wdata[1:0];
            irq_reg      <= ctrl_reg[1] & (|edge_reg);
            scan_cnt_reg <= scan_cnt_reg + SCAN_BITS'(1);
            idx_reg      <= idx_next;
            seg_reg      <= seg_next;
            dig_reg      <= dig_next;
            rdata_reg    <= rdata_next;
        end
    end

    assign led   = ~led_reg;
    assign seg   = seg_reg;
    assign dig   = dig_reg;
    assign irq   = irq_reg;
    assign rdata = rdata_reg;

endmodule

// File: tb/tb_io_ctrl.sv
// Directed bench for io_ctrl with short debounce and scan counters.
module tb_io_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [2:0]   addr = 3'd0;
    logic [W-1:0] wdata = '0;
    logic         we = 1'b0;
    logic [W-1:0] rdata;
    logic [3:0]   btn = 4'h0;
    logic [3:0]   led;
    logic [7:0]   seg;
    logic [3:0]   dig;
    logic         irq;

    int checks = 0;
    int errors = 0;
    int cyc;

    io_ctrl #(.WORD_SIZE(16), .N_BTN(4), .N_LED(4), .N_DIG(4), .DEB_BITS(2), .SCAN_BITS(2)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
        .btn(btn), .led(led), .seg(seg), .dig(dig), .irq(irq)
    );

    always #5 clk = ~clk;

    // Edges seen since the last reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        addr = a; wdata = d; we = 1'b1;
        step();
        we = 1'b0;
        $display("write addr=%0d data=%h", a, d);
    endtask

    task automatic rd(input logic [2:0] a, output logic [W-1:0] v);
        addr = a; we = 1'b0;
        step();
        v = rdata;
        $display("read  addr=%0d data=%h", a, v);
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        repeat (2) step();
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 16'h0000); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected %b", irq, 1'b0); end
        checks++; if (led !== 4'hF) begin errors++; $display("FAIL reset_led: got %b expected %b", led, 4'hF); end
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h expected %h", seg, 8'hFF); end
        checks++; if (dig !== 4'hF) begin errors++; $display("FAIL reset_dig: got %b expected %b", dig, 4'hF); end
        reset = 1'b1;
        checks++; if (dig !== 4'hF) begin errors++; $display("FAIL release_dig: got %b expected %b", dig, 4'hF); end
        rd(3'd4, v);
        checks++; if (v !== 16'h0001) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", v, 16'h0001); end
        rd(3'd0, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_disp: got %h expected %h", v, 16'h0000); end
    endtask

    task automatic test_display();
        logic [3:0] exp_dig [4];
        logic [7:0] exp_seg [4];
        int n;
        exp_dig = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
        wr(3'd0, 16'h12AF);
        wr(3'd4, 16'h0001);
        n = 0;
        while (dig !== 4'b0111 && n < 40) begin step(); n++; end
        n = 0;
        while (dig === 4'b0111 && n < 8) begin step(); n++; end
        checks++; if (n == 0 || n >= 8) begin errors++; $display("FAIL disp_sync: got %0d cycles expected 1..7", n); end
        for (int i = 0; i < 4; i++) begin
            $display("scan digit %0d dig=%b seg=%h", i, dig, seg);
            checks++; if (dig !== exp_dig[i]) begin errors++; $display("FAIL disp_dig%0d: got %b expected %b", i, dig, exp_dig[i]); end
            checks++; if (seg !== exp_seg[i]) begin errors++; $display("FAIL disp_seg%0d: got %h expected %h", i, seg, exp_seg[i]); end
            repeat (3) step();
            checks++; if (dig !== exp_dig[i]) begin errors++; $display("FAIL disp_hold%0d: got %b expected %b", i, dig, exp_dig[i]); end
            step();
        end
    endtask

    task automatic test_led_ctrl();
        logic [W-1:0] v;
        wr(3'd1, 16'h0005);
        checks++; if (led !== 4'b1010) begin errors++; $display("FAIL led_pins: got %b expected %b", led, 4'b1010); end
        rd(3'd1, v);
        checks++; if (v !== 16'h0005) begin errors++; $display("FAIL led_read: got %h expected %h", v, 16'h0005); end
        addr = 3'd1; wdata = 16'h0003; we = 1'b1;
        step();
        we = 1'b0;
        $display("write+read addr=1 data=0003 rdata=%h", rdata);
        checks++; if (rdata !== 16'h0005) begin errors++; $display("FAIL rw_same_cycle: got %h expected %h", rdata, 16'h0005); end
        step();
        checks++; if (rdata !== 16'h0003) begin errors++; $display("FAIL rw_after: got %h expected %h", rdata, 16'h0003); end
        wr(3'd1, 16'hFFFF);
        rd(3'd1, v);
        checks++; if (v !== 16'h000F) begin errors++; $display("FAIL led_unimpl: got %h expected %h", v, 16'h000F); end
        checks++; if (led !== 4'b0000) begin errors++; $display("FAIL led_all_on: got %b expected %b", led, 4'b0000); end
        wr(3'd2, 16'hFFFF);
        rd(3'd2, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL level_ro: got %h expected %h", v, 16'h0000); end
        wr(3'd4, 16'h0000);
        step();
        checks++; if (dig !== 4'hF) begin errors++; $display("FAIL blank_dig: got %b expected %b", dig, 4'hF); end
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL blank_seg: got %h expected %h", seg, 8'hFF); end
        rd(3'd6, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL addr6: got %h expected %h", v, 16'h0000); end
        rd(3'd4, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL ctrl_zero: got %h expected %h", v, 16'h0000); end
    endtask

    task automatic test_glitch_filter();
        logic [W-1:0] v;
        btn[0] = 1'b1;
        repeat (3) step();
        btn[0] = 1'b0;
        repeat (12) step();
        rd(3'd2, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL glitch_level: got %h expected %h", v, 16'h0000); end
        rd(3'd3, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL glitch_edge: got %h expected %h", v, 16'h0000); end
    endtask

    task automatic test_debounce_irq();
        logic [W-1:0] v;
        btn[2] = 1'b1;
        repeat (12) step();
        rd(3'd2, v);
        checks++; if (v !== 16'h0004) begin errors++; $display("FAIL deb_level: got %h expected %h", v, 16'h0004); end
        rd(3'd3, v);
        checks++; if (v !== 16'h0004) begin errors++; $display("FAIL deb_edge: got %h expected %h", v, 16'h0004); end
        wr(3'd4, 16'h0003);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before: got %b expected %b", irq, 1'b0); end
        step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected %b", irq, 1'b1); end
        btn[2] = 1'b0;
    endtask

    task automatic test_edge_clear();
        logic [W-1:0] v;
        int t1, t2;
        btn[1] = 1'b1;
        repeat (20) step();
        rd(3'd2, v);
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL ec_level_pre: got %h expected %h", v, 16'h0002); end
        rd(3'd3, v);
        checks++; if (v !== 16'h0006) begin errors++; $display("FAIL ec_edge_pre: got %h expected %h", v, 16'h0006); end
        btn[2] = 1'b1;
        // Level rises on the second tick that sees the synchronised high.
        t1 = cyc + 3;
        while (t1 % 4 != 0) t1++;
        t2 = t1 + 4;
        while (cyc < t2 - 1) step();
        wr(3'd3, 16'h0006);
        rd(3'd3, v);
        checks++; if (v !== 16'h0004) begin errors++; $display("FAIL ec_set_wins: got %h expected %h", v, 16'h0004); end
        rd(3'd2, v);
        checks++; if (v !== 16'h0006) begin errors++; $display("FAIL ec_level: got %h expected %h", v, 16'h0006); end
        wr(3'd3, 16'h0004);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ec_irq_hold: got %b expected %b", irq, 1'b1); end
        step();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ec_irq_fall: got %b expected %b", irq, 1'b0); end
        rd(3'd3, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL ec_cleared: got %h expected %h", v, 16'h0000); end
    endtask

    task automatic test_reset_mid_scan();
        logic [W-1:0] v;
        wr(3'd0, 16'hFFFF);
        wr(3'd4, 16'h0001);
        repeat (6) step();
        #2 reset = 1'b0;
        #1;
        $display("reset asserted rdata=%h irq=%b led=%b seg=%h dig=%b", rdata, irq, led, seg, dig);
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL mid_rdata: got %h expected %h", rdata, 16'h0000); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b expected %b", irq, 1'b0); end
        checks++; if (led !== 4'hF) begin errors++; $display("FAIL mid_led: got %b expected %b", led, 4'hF); end
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL mid_seg: got %h expected %h", seg, 8'hFF); end
        checks++; if (dig !== 4'hF) begin errors++; $display("FAIL mid_dig: got %b expected %b", dig, 4'hF); end
        repeat (2) step();
        addr = 3'd2;
        reset = 1'b1;
        checks++; if (dig !== 4'hF) begin errors++; $display("FAIL mid_release_dig: got %b expected %b", dig, 4'hF); end
        repeat (8) step();
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL first_tick_early: got %h expected %h", rdata, 16'h0000); end
        step();
        checks++; if (rdata !== 16'h0006) begin errors++; $display("FAIL first_tick_level: got %h expected %h", rdata, 16'h0006); end
        rd(3'd4, v);
        checks++; if (v !== 16'h0001) begin errors++; $display("FAIL mid_ctrl: got %h expected %h", v, 16'h0001); end
        rd(3'd3, v);
        checks++; if (v !== 16'h0006) begin errors++; $display("FAIL mid_edge: got %h expected %h", v, 16'h0006); end
    endtask

    initial begin
        test_reset();
        test_display();
        test_led_ctrl();
        test_glitch_filter();
        test_debounce_irq();
        test_edge_clear();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
